lsu_bus_master: RTL

Load/store unit that takes one memory-access command per transaction, as produced by the instruction decoder (`mem_wen`, `mem_ren`, `rw_type`), and turns it into a single word-aligned request on the data-memory bus. It computes byte strobes, replicates store data, and extracts and extends load data. It reports completion or error back to the core with a one-cycle `done` pulse. It sits between the execute stage (address from the ALU, store data from the register file) and the data memory.

---
 rtl/lsu_bus_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_master.sv
// Load/store bus master: turns one decoded memory command into a single word-aligned
// data-memory bus request, with strobe/lane handling, load extension and a timeout.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [3:0]  rw_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  lane_q;
  logic [2:0]  size_q;
  logic        uns_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        bus_valid_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_wstrb_q;
  logic [31:0] bus_wdata_q;

  logic        accept;
  logic        size_ok;
  logic        misalign;
  logic        bad_cmd;
  logic        timeout_hit;

  // size is the one-hot {w,h,b} field of rw_type
  function automatic logic [3:0] strb_f(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'b100:  strb_f = 4'b1111;
      3'b010:  strb_f = 4'b0011 << {a[1], 1'b0};
      3'b001:  strb_f = 4'b0001 << a;
      default: strb_f = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] sz, input logic [31:0] d);
    case (sz)
      3'b100:  wdata_f = d;
      3'b010:  wdata_f = {2{d[15:0]}};
      3'b001:  wdata_f = {4{d[7:0]}};
      default: wdata_f = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] sz, input logic uns,
                                         input logic [1:0] lane, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {lane, 3'b000});
    h = 16'(d >> {lane[1], 4'b0000});
    case (sz)
      3'b100:  load_f = d;
      3'b010:  load_f = {{16{h[15] & ~uns}}, h};
      3'b001:  load_f = {{24{b[7] & ~uns}}, b};
      default: load_f = 32'h0000_0000;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready & (mem_wen | mem_ren);
  assign size_ok   = (rw_type[2:0] == 3'b100) | (rw_type[2:0] == 3'b010) |
                     (rw_type[2:0] == 3'b001);
  assign misalign  = (rw_type[1] & addr[0]) | (rw_type[2] & (addr[1:0] != 2'b00));
  assign bad_cmd   = (mem_wen & mem_ren) | ~size_ok | misalign;
  // Abort decision is made one cycle early so done lands exactly TIMEOUT cycles after accept.
  assign timeout_hit = ({1'b0, cnt_q} + 17'd2) >= 17'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      lane_q      <= 2'd0;
      size_q      <= 3'd0;
      uns_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q <= 16'd0;
            if (bad_cmd) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0000_0000;
            end else begin
              state_q     <= ADDR;
              lane_q      <= addr[1:0];
              size_q      <= rw_type[2:0];
              uns_q       <= rw_type[3];
              bus_valid_q <= 1'b1;
              bus_we_q    <= mem_wen;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_wstrb_q <= mem_wen ? strb_f(rw_type[2:0], addr[1:0]) : 4'b0000;
              bus_wdata_q <= mem_wen ? wdata_f(rw_type[2:0], wdata) : 32'h0000_0000;
            end
          end
        end
        ADDR: begin
          cnt_q <= cnt_q + 16'd1;
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            if (bus_we_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= 32'h0000_0000;
            end else begin
              state_q <= RESP;
            end
          end else if (timeout_hit) begin
            bus_valid_q <= 1'b0;
            state_q     <= DONE;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= 32'h0000_0000;
          end
        end
        RESP: begin
          cnt_q <= cnt_q + 16'd1;
          if (bus_rvalid) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= load_f(size_q, uns_q, lane_q, bus_rdata);
          end else if (timeout_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= 32'h0000_0000;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0000_0000;
        end
        default: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          bus_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule
